// File: rtl/cmp_pkg.sv
// ---------------------------------------------------------------------------
// cmp_pkg
// Shared types and the result decode for the pipelined comparator.
//   cmp_op_t    : 3-bit operation select (signed order, unsigned order, eq/ne)
//   cmp_flags_t : the three primitive relations computed once per operand pair
//   cmp_decode  : maps the primitive relations plus an op to the 1-bit result
// ---------------------------------------------------------------------------
package cmp_pkg;

  typedef enum logic [2:0] {
    OP_SLT = 3'd0,
    OP_SLE = 3'd1,
    OP_SGT = 3'd2,
    OP_SGE = 3'd3,
    OP_ULT = 3'd4,
    OP_ULE = 3'd5,
    OP_EQ  = 3'd6,
    OP_NE  = 3'd7
  } cmp_op_t;

  // Every supported op is a boolean function of these three relations, so the
  // wide comparison happens once at the front and only 3 bits travel the pipe.
  typedef struct packed {
    logic lt_s;
    logic lt_u;
    logic eq;
  } cmp_flags_t;

  function automatic logic cmp_decode(input cmp_flags_t flags, input cmp_op_t sel);
    logic res;
    case (sel)
      OP_SLT:  res = flags.lt_s;
      OP_SLE:  res = flags.lt_s | flags.eq;
      OP_SGT:  res = ~(flags.lt_s | flags.eq);
      OP_SGE:  res = ~flags.lt_s;
      OP_ULT:  res = flags.lt_u;
      OP_ULE:  res = flags.lt_u | flags.eq;
      OP_EQ:   res = flags.eq;
      OP_NE:   res = ~flags.eq;
      // NOTE: a default arm keeps the decode fully specified even though all
      // eight codes are listed, so no tool can infer a latch or an X path.
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cmp_pipe_stage.sv
// ---------------------------------------------------------------------------
// cmp_pipe_stage
// One valid/ready register slice carrying comparison flags and the op.
// The slice loads whenever it is empty or its current entry is leaving.
//   CLK        : clock, rising edge
//   ASYNCRESET : asynchronous active-high reset, clears valid, flags and op
//   in_valid   : upstream entry present
//   in_flags   : upstream flags
//   in_op      : upstream op
//   out_valid  : this slice holds an entry
//   out_ready  : downstream accepts this slice's entry this cycle
//   out_flags  : held flags
//   out_op     : held op
// ---------------------------------------------------------------------------
module cmp_pipe_stage
  import cmp_pkg::*;
(
  input  logic       CLK,
  input  logic       ASYNCRESET,
  input  logic       in_valid,
  input  cmp_flags_t in_flags,
  input  cmp_op_t    in_op,
  output logic       out_valid,
  input  logic       out_ready,
  output cmp_flags_t out_flags,
  output cmp_op_t    out_op
);

  logic load;

  assign load = ~out_valid | out_ready;

  // NOTE: sequential state uses non-blocking assignments so every slice samples
  // its upstream neighbour's pre-edge value and the chain shifts by one place.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      out_valid <= 1'b0;
      // NOTE: the payload is reset too, not just valid, so the decoded output
      // reads a defined 0 while the pipe is empty after reset.
      out_flags <= '0;
      out_op    <= OP_SLT;
    end else if (load) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_flags <= in_flags;
        out_op    <= in_op;
      end
    end
  end

endmodule

// File: rtl/cmp_pipe.sv
// ---------------------------------------------------------------------------
// cmp_pipe
// Pipelined comparator with runtime op select and valid/ready on both sides.
// The front computes signed-less, unsigned-less and equal; STAGES register
// slices carry them with the op; the output decodes the last slice.
//   WIDTH  : operand width, 1..64
//   STAGES : register slices, 1..4 (latency and capacity)
//   CLK        : clock, rising edge
//   ASYNCRESET : asynchronous active-high reset, discards in-flight entries
//   I0, I1     : left and right operands
//   op         : operation select (cmp_op_t encoding)
//   in_valid   : operands valid
//   in_ready   : block accepts a transfer this cycle (combinational)
//   O          : comparison result
//   out_valid  : O is valid
//   out_ready  : consumer accepts O this cycle
// ---------------------------------------------------------------------------
module cmp_pipe
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 7,
  parameter int STAGES = 2
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             O,
  output logic             out_valid,
  input  logic             out_ready
);

  cmp_flags_t  flags_in;
  logic [STAGES:0] vld;
  cmp_flags_t  flags_chain [STAGES+1];
  cmp_op_t     op_chain    [STAGES+1];

  always_comb begin
    flags_in      = '0;
    flags_in.lt_s = $signed(I0) < $signed(I1);
    flags_in.lt_u = I0 < I1;
    flags_in.eq   = I0 == I1;
  end

  assign vld[0]         = in_valid;
  assign flags_chain[0] = flags_in;
  assign op_chain[0]    = cmp_op_t'(op);

  // A slice's downstream is ready unless every slice from there to the output
  // is occupied and the consumer is stalling. Writing this directly from the
  // valid bits avoids a ready signal rippling through its own vector.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic dn_ready;

    if (i == STAGES - 1) begin : g_last
      assign dn_ready = out_ready;
    end else begin : g_mid
      assign dn_ready = out_ready | ~(&vld[STAGES:i+2]);
    end

    cmp_pipe_stage u_stage (
      .CLK       (CLK),
      .ASYNCRESET(ASYNCRESET),
      .in_valid  (vld[i]),
      .in_flags  (flags_chain[i]),
      .in_op     (op_chain[i]),
      .out_valid (vld[i+1]),
      .out_ready (dn_ready),
      .out_flags (flags_chain[i+1]),
      .out_op    (op_chain[i+1])
    );
  end

  // Equivalent to !v1 | advance1: the front slice can take a new entry unless
  // the whole pipe is full and the consumer is stalling.
  assign in_ready  = out_ready | ~(&vld[STAGES:1]);
  assign out_valid = vld[STAGES];
  assign O         = cmp_decode(flags_chain[STAGES], op_chain[STAGES]);

endmodule

// File: tb/tb_cmp_pipe.sv
// ---------------------------------------------------------------------------
// tb_cmp_pipe
// Scoreboard bench for cmp_pipe. A WIDTH=7/STAGES=2 instance runs directed
// sign-boundary, op sweep, backpressure and mid-stream reset sequences; four
// more instances (WIDTH 1/64 x STAGES 1/4) each stream random vectors with
// out_ready high. Expected results come from an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_cmp_pipe;

  typedef struct {
    logic exp;
    int   due;
    logic lat;
  } sb_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: signed order of w-bit values equals unsigned order after
  // flipping the sign bit; each op is then a direct relational operator.
  function automatic logic ref_cmp(input logic [63:0] a_in, input logic [63:0] b_in,
                                   input int w, input logic [2:0] sel);
    logic [63:0] mask, bias, a, b, sa, sb;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a    = a_in & mask;
    b    = b_in & mask;
    bias = 64'd1 << (w - 1);
    sa   = a ^ bias;
    sb   = b ^ bias;
    case (sel)
      3'd0:    return sa <  sb;
      3'd1:    return sa <= sb;
      3'd2:    return sa >  sb;
      3'd3:    return sa >= sb;
      3'd4:    return a  <  b;
      3'd5:    return a  <= b;
      3'd6:    return a  == b;
      default: return a  != b;
    endcase
  endfunction

  // ---------------- main instance: WIDTH=7, STAGES=2 ----------------
  localparam int MW = 7;
  localparam int MS = 2;

  logic          m_rst, m_iv, m_ir, m_o, m_ov, m_or;
  logic [MW-1:0] m_a, m_b;
  logic [2:0]    m_op;
  sb_t           m_q[$];

  cmp_pipe #(.WIDTH(MW), .STAGES(MS)) u_dut (
    .CLK       (CLK),
    .ASYNCRESET(m_rst),
    .I0        (m_a),
    .I1        (m_b),
    .op        (m_op),
    .in_valid  (m_iv),
    .in_ready  (m_ir),
    .O         (m_o),
    .out_valid (m_ov),
    .out_ready (m_or)
  );

  always @(negedge CLK) begin : m_monitor
    sb_t e;
    if (m_ov && m_or) begin
      if (m_q.size() == 0) begin
        check("m_unexpected_out", 64'(m_ov), 64'd0);
      end else begin
        e = m_q.pop_front();
        check("m_result", 64'(m_o), 64'(e.exp));
        if (e.lat) check("m_latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic m_drive(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic [2:0] sel);
    m_a  = a;
    m_b  = b;
    m_op = sel;
    m_iv = 1'b1;
  endtask

  task automatic m_push(input logic [MW-1:0] a, input logic [MW-1:0] b,
                        input logic [2:0] sel, input logic lat);
    sb_t e;
    e.exp = ref_cmp(64'(a), 64'(b), MW, sel);
    e.due = cyc + MS;
    e.lat = lat;
    m_q.push_back(e);
  endtask

  // Presents one vector and returns at the negedge before its transfer edge.
  task automatic m_send(input logic [MW-1:0] a, input logic [MW-1:0] b,
                        input logic [2:0] sel, input logic lat);
    @(posedge CLK);
    #1 m_drive(a, b, sel);
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (m_ir) begin
        m_push(a, b, sel, lat);
        return;
      end
    end
    check("m_send_timeout", 64'(m_ir), 64'd1);
  endtask

  task automatic m_idle_drain();
    @(posedge CLK);
    #1 m_iv = 1'b0;
    for (int i = 0; i < 40 && m_q.size() != 0; i++) @(negedge CLK);
    check("m_drained", 64'(m_q.size()), 64'd0);
  endtask

  logic [MW-1:0] bp_a [6];
  logic [MW-1:0] bp_b [6];
  logic [2:0]    bp_op[6];

  initial begin
    m_rst = 1'b1;
    m_iv  = 1'b0;
    m_a   = '0;
    m_b   = '0;
    m_op  = '0;
    m_or  = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_out_valid", 64'(m_ov), 64'd0);
    check("reset_o", 64'(m_o), 64'd0);
    m_iv = 1'b1;   // ignored while reset is held
    @(posedge CLK);
    #1 m_iv = 1'b0;
    m_rst = 1'b0;
    @(negedge CLK);
    check("reset_in_ready", 64'(m_ir), 64'd1);
    check("reset_ignored_valid", 64'(m_ov), 64'd0);

    // Sign boundary: 0x40 is -64 signed but 64 unsigned.
    m_send(7'h40, 7'h3F, 3'd0, 1'b1);
    m_send(7'h40, 7'h3F, 3'd4, 1'b1);
    // All ops on equal operands, then -1 sge 0.
    for (int k = 0; k < 8; k++) m_send(7'h55, 7'h55, 3'(k), 1'b1);
    m_send(7'h7F, 7'h00, 3'd3, 1'b1);
    m_idle_drain();

    // Backpressure: fill with the consumer stalled, then release.
    for (int k = 0; k < 6; k++) begin
      bp_a[k]  = 7'($urandom);
      bp_b[k]  = (k == 2) ? bp_a[k] : 7'($urandom);
      bp_op[k] = 3'($urandom_range(0, 7));
    end
    @(posedge CLK);
    #1 m_or = 1'b0;
    m_send(bp_a[0], bp_b[0], bp_op[0], 1'b0);
    m_send(bp_a[1], bp_b[1], bp_op[1], 1'b0);
    @(posedge CLK);
    #1 m_drive(bp_a[2], bp_b[2], bp_op[2]);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("bp_in_ready_low", 64'(m_ir), 64'd0);
      check("bp_out_valid_hold", 64'(m_ov), 64'd1);
      check("bp_o_hold", 64'(m_o), 64'(ref_cmp(64'(bp_a[0]), 64'(bp_b[0]), MW, bp_op[0])));
    end
    @(posedge CLK);
    #1 m_or = 1'b1;
    @(negedge CLK);
    check("bp_release_ready", 64'(m_ir), 64'd1);
    if (m_ir) m_push(bp_a[2], bp_b[2], bp_op[2], 1'b0);
    for (int k = 3; k < 6; k++) m_send(bp_a[k], bp_b[k], bp_op[k], 1'b0);
    m_idle_drain();

    // Mid-stream reset with two entries in flight.
    m_send(7'h12, 7'h34, 3'd0, 1'b1);
    m_send(7'h34, 7'h34, 3'd6, 1'b1);
    @(posedge CLK);
    #1 m_drive(7'h01, 7'h02, 3'd4);
    #1 m_rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(m_ov), 64'd0);
    check("midrst_o", 64'(m_o), 64'd0);
    m_q.delete();
    @(posedge CLK);
    #1 m_iv = 1'b0;
    m_rst = 1'b0;
    @(negedge CLK);
    check("midrst_in_ready", 64'(m_ir), 64'd1);
    check("midrst_no_stale", 64'(m_ov), 64'd0);
    repeat (8) @(negedge CLK);

    for (int i = 0; i < 5000 && done_cnt < 4; i++) @(posedge CLK);
    check("sweep_done", 64'(done_cnt), 64'd4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- parameter sweep: WIDTH {1,64} x STAGES {1,4} ----------------
  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int SW = (g < 2) ? 1 : 64;
    localparam int SS = (g % 2 == 0) ? 1 : 4;

    logic          s_rst, s_iv, s_ir, s_o, s_ov, s_or;
    logic [SW-1:0] s_a, s_b;
    logic [2:0]    s_op;
    sb_t           s_q[$];

    cmp_pipe #(.WIDTH(SW), .STAGES(SS)) u_dut (
      .CLK       (CLK),
      .ASYNCRESET(s_rst),
      .I0        (s_a),
      .I1        (s_b),
      .op        (s_op),
      .in_valid  (s_iv),
      .in_ready  (s_ir),
      .O         (s_o),
      .out_valid (s_ov),
      .out_ready (s_or)
    );

    always @(negedge CLK) begin : s_monitor
      sb_t e;
      if (s_ov && s_or) begin
        if (s_q.size() == 0) begin
          check("swp_unexpected_out", 64'(s_ov), 64'd0);
        end else begin
          e = s_q.pop_front();
          check("swp_result", 64'(s_o), 64'(e.exp));
          check("swp_latency", 64'(cyc), 64'(e.due));
        end
      end
    end

    initial begin : s_stim
      logic [63:0] r;
      sb_t e;
      s_rst = 1'b1;
      s_iv  = 1'b0;
      s_or  = 1'b1;
      s_a   = '0;
      s_b   = '0;
      s_op  = '0;
      repeat (3) @(posedge CLK);
      #1 s_rst = 1'b0;
      @(negedge CLK);
      check("swp_reset_ready", 64'(s_ir), 64'd1);
      check("swp_reset_valid", 64'(s_ov), 64'd0);
      // Vector 0 is I0=1, I1=0, slt: true only when WIDTH=1 (1 means -1).
      for (int n = 0; n < 101; n++) begin
        @(posedge CLK);
        #1;
        if (n == 0) begin
          s_a    = '0;
          s_a[0] = 1'b1;
          s_b    = '0;
          s_op   = 3'd0;
        end else begin
          r    = {$urandom(), $urandom()};
          s_a  = r[SW-1:0];
          r    = {$urandom(), $urandom()};
          s_b  = ($urandom_range(0, 3) == 0) ? s_a : r[SW-1:0];
          s_op = 3'($urandom_range(0, 7));
        end
        s_iv = 1'b1;
        @(negedge CLK);
        check("swp_in_ready", 64'(s_ir), 64'd1);
        if (s_ir) begin
          e.exp = ref_cmp(64'(s_a), 64'(s_b), SW, s_op);
          e.due = cyc + SS;
          e.lat = 1'b1;
          s_q.push_back(e);
        end
      end
      @(posedge CLK);
      #1 s_iv = 1'b0;
      repeat (SS + 2) @(negedge CLK);
      check("swp_drained", 64'(s_q.size()), 64'd0);
      done_cnt++;
    end
  end

endmodule
